// File: rtl/acc_cpu.sv
// Accumulator CPU: 2-cycle fetch/execute core with a ready/valid output port.
// Program memory is external and combinational; data RAM is internal and never reset.
module acc_cpu #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 5,
    parameter int RAM_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PC_W-1:0]   instr_addr,
    input  logic [DATA_W+3:0] instr_data,
    output logic [DATA_W-1:0] out_port,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              fetch,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] acc,
    output logic              halted
);

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXEC,
        ST_OUT_WAIT,
        ST_HALT
    } state_t;

    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_LD  = 4'h7;
    localparam logic [3:0] OP_ST  = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_JC  = 4'hB;
    localparam logic [3:0] OP_OUT = 4'hC;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t              state_reg, state_next;
    logic [PC_W-1:0]     pc_reg, pc_next;
    logic [DATA_W-1:0]   acc_reg, acc_next;
    logic [DATA_W+3:0]   ir_reg, ir_next;
    logic                z_reg, z_next;
    logic                c_reg, c_next;
    logic [DATA_W-1:0]   out_port_reg, out_port_next;
    logic                out_valid_reg, out_valid_next;

    logic [DATA_W-1:0]   ram [2**RAM_AW];
    logic [3:0]          opcode;
    logic [DATA_W-1:0]   imm;
    logic [RAM_AW-1:0]   ram_addr;
    logic [DATA_W-1:0]   ram_rd;
    logic                ram_we;
    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     diff;
    logic                acc_upd;
    logic [DATA_W-1:0]   acc_val;

    assign opcode   = ir_reg[DATA_W+3:DATA_W];
    assign imm      = ir_reg[DATA_W-1:0];
    assign ram_addr = imm[RAM_AW-1:0];
    assign ram_rd   = ram[ram_addr];
    // Extra top bit holds carry-out for ADD and borrow for SUB.
    assign sum      = {1'b0, acc_reg} + {1'b0, imm};
    assign diff     = {1'b0, acc_reg} - {1'b0, imm};

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        acc_next       = acc_reg;
        ir_next        = ir_reg;
        z_next         = z_reg;
        c_next         = c_reg;
        out_port_next  = out_port_reg;
        out_valid_next = out_valid_reg;
        ram_we         = 1'b0;
        acc_upd        = 1'b0;
        acc_val        = '0;
        case (state_reg)
            ST_FETCH: begin
                ir_next    = instr_data;
                pc_next    = pc_reg + PC_W'(1);
                state_next = ST_EXEC;
            end
            ST_EXEC: begin
                state_next = ST_FETCH;
                case (opcode)
                    OP_LDI: begin acc_upd = 1'b1; acc_val = imm; end
                    OP_ADD: begin acc_upd = 1'b1; acc_val = sum[DATA_W-1:0];  c_next = sum[DATA_W];  end
                    OP_SUB: begin acc_upd = 1'b1; acc_val = diff[DATA_W-1:0]; c_next = diff[DATA_W]; end
                    OP_AND: begin acc_upd = 1'b1; acc_val = acc_reg & imm; end
                    OP_OR:  begin acc_upd = 1'b1; acc_val = acc_reg | imm; end
                    OP_XOR: begin acc_upd = 1'b1; acc_val = acc_reg ^ imm; end
                    OP_LD:  begin acc_upd = 1'b1; acc_val = ram_rd; end
                    OP_ST:  ram_we = 1'b1;
                    OP_JMP: pc_next = imm[PC_W-1:0];
                    OP_JZ:  if (z_reg) pc_next = imm[PC_W-1:0];
                    OP_JC:  if (c_reg) pc_next = imm[PC_W-1:0];
                    OP_OUT: begin
                        out_port_next  = acc_reg;
                        out_valid_next = 1'b1;
                        state_next     = ST_OUT_WAIT;
                    end
                    OP_HLT: state_next = ST_HALT;
                    default: ;
                endcase
                if (acc_upd) begin
                    acc_next = acc_val;
                    z_next   = (acc_val == '0);
                end
            end
            ST_OUT_WAIT: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = ST_FETCH;
                end
            end
            ST_HALT: ;
            default: state_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_FETCH;
            pc_reg        <= '0;
            acc_reg       <= '0;
            ir_reg        <= '0;
            z_reg         <= 1'b0;
            c_reg         <= 1'b0;
            out_port_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            acc_reg       <= acc_next;
            ir_reg        <= ir_next;
            z_reg         <= z_next;
            c_reg         <= c_next;
            out_port_reg  <= out_port_next;
            out_valid_reg <= out_valid_next;
        end
    end

    // Store is suppressed while reset is asserted so reset wins over every update.
    always_ff @(posedge clk) begin
        if (ram_we && !rst) begin
            ram[ram_addr] <= acc_reg;
        end
    end

    assign instr_addr = pc_reg;
    assign pc         = pc_reg;
    assign acc        = acc_reg;
    assign out_port   = out_port_reg;
    assign out_valid  = out_valid_reg;
    assign fetch      = (state_reg == ST_FETCH);
    assign halted     = (state_reg == ST_HALT);

endmodule

// File: tb/tb_acc_cpu.sv
// Bench for acc_cpu: directed programs plus random programs checked against an
// instruction-level model; a second instance covers PC_W=3 / DATA_W=16.
module tb_acc_cpu;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        rst, out_ready;
    logic [4:0]  instr_addr, pc;
    logic [11:0] instr_data;
    logic [7:0]  out_port, acc;
    logic        out_valid, fetch, halted;
    logic [11:0] prog [32];
    assign instr_data = prog[instr_addr];

    acc_cpu dut (
        .clk(clk), .rst(rst), .instr_addr(instr_addr), .instr_data(instr_data),
        .out_port(out_port), .out_valid(out_valid), .out_ready(out_ready),
        .fetch(fetch), .pc(pc), .acc(acc), .halted(halted)
    );

    // Wide-data, short-PC instance
    logic        rst2, ready2;
    logic [2:0]  instr_addr2, pc2;
    logic [19:0] instr_data2;
    logic [15:0] out_port2, acc2;
    logic        out_valid2, fetch2, halted2;
    logic [19:0] prog2 [8];
    assign instr_data2 = prog2[instr_addr2];

    acc_cpu #(.DATA_W(16), .PC_W(3), .RAM_AW(4)) dut2 (
        .clk(clk), .rst(rst2), .instr_addr(instr_addr2), .instr_data(instr_data2),
        .out_port(out_port2), .out_valid(out_valid2), .out_ready(ready2),
        .fetch(fetch2), .pc(pc2), .acc(acc2), .halted(halted2)
    );

    int tests_run = 0;
    int tests_failed = 0;
    bit rand_ready = 0;
    int valid_cnt = 0;
    logic [7:0] got_q [$];

    // Reference model state (instruction-level)
    int mpc, macc, mz, mc, mhalt;
    int mram [16];
    int exp_q [$];

    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) got_q.push_back(out_port);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (out_valid) valid_cnt++;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    function automatic logic [11:0] ins(input int op, input int imm);
        return {4'(op), 8'(imm)};
    endfunction

    function automatic logic [19:0] ins2(input int op, input int imm);
        return {4'(op), 16'(imm)};
    endfunction

    task automatic reset1();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        got_q.delete();
        valid_cnt = 0;
    endtask

    task automatic reset2();
        rst2 = 1'b1;
        tick();
        tick();
        rst2 = 1'b0;
    endtask

    task automatic run_halt(input int max, output int cyc);
        cyc = 0;
        while (!halted && cyc < max) begin
            tick();
            cyc++;
        end
        if (!halted) check("halt_timeout", 32'(halted), 1);
    endtask

    task automatic model_step(input logic [11:0] word);
        int op, imm, r;
        op  = int'(word[11:8]);
        imm = int'(word[7:0]);
        mpc = (mpc + 1) % 32;
        case (op)
            1:  begin macc = imm; mz = (macc == 0); end
            2:  begin r = macc + imm; mc = (r > 255); macc = r % 256; mz = (macc == 0); end
            3:  begin mc = (macc < imm); macc = (macc - imm + 256) % 256; mz = (macc == 0); end
            4:  begin macc = macc & imm; mz = (macc == 0); end
            5:  begin macc = macc | imm; mz = (macc == 0); end
            6:  begin macc = macc ^ imm; mz = (macc == 0); end
            7:  begin macc = mram[imm % 16]; mz = (macc == 0); end
            8:  mram[imm % 16] = macc;
            9:  mpc = imm % 32;
            10: if (mz != 0) mpc = imm % 32;
            11: if (mc != 0) mpc = imm % 32;
            12: exp_q.push_back(macc);
            15: mhalt = 1;
            default: ;
        endcase
    endtask

    initial begin
        int cyc, op;
        rst = 1'b1; out_ready = 1'b1; rst2 = 1'b1; ready2 = 1'b1;
        for (int i = 0; i < 32; i++) prog[i] = '0;
        for (int i = 0; i < 8; i++) prog2[i] = '0;

        // LDI 5; ADD 3; OUT; HLT
        prog[0] = ins(1, 5); prog[1] = ins(2, 3); prog[2] = ins(12, 0); prog[3] = ins(15, 0);
        reset1();
        check("rst_fetch", 32'(fetch), 1);
        check("rst_pc", 32'(pc), 0);
        check("rst_acc", 32'(acc), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_port", 32'(out_port), 0);
        check("rst_halted", 32'(halted), 0);
        run_halt(50, cyc);
        check("basic_cycles", cyc, 9);
        check("basic_pulses", valid_cnt, 1);
        check("basic_xfers", got_q.size(), 1);
        check("basic_port", 32'(out_port), 8'h08);
        check("basic_acc_frozen", 32'(acc), 8'h08);
        tick(); tick();
        check("halt_pc_frozen", 32'(pc), 4);
        check("halt_stays", 32'(halted), 1);

        // Carry from ADD, JC taken over LDI 11, Z observed through JZ
        prog[0] = ins(1, 'hFF); prog[1] = ins(2, 1); prog[2] = ins(11, 5);
        prog[3] = ins(1, 'h11); prog[4] = ins(1, 'h11); prog[5] = ins(12, 0);
        prog[6] = ins(10, 8); prog[7] = ins(1, 'h33); prog[8] = ins(15, 0);
        reset1();
        run_halt(60, cyc);
        check("jc_acc", 32'(acc), 0);
        check("jc_port", 32'(out_port), 0);
        check("jc_xfers", got_q.size(), 1);
        check("jz_pc", 32'(pc), 9);

        // Store then load the same address
        prog[0] = ins(1, 'h2A); prog[1] = ins(8, 3); prog[2] = ins(1, 0);
        prog[3] = ins(7, 3); prog[4] = ins(12, 0); prog[5] = ins(15, 0);
        reset1();
        run_halt(60, cyc);
        check("stld_port", 32'(out_port), 8'h2A);
        check("stld_xfers", got_q.size(), 1);

        // Back-pressure: ready low for 10 cycles
        prog[0] = ins(1, 'h5A); prog[1] = ins(12, 0); prog[2] = ins(15, 0);
        out_ready = 1'b0;
        reset1();
        cyc = 0;
        while (!out_valid && cyc < 20) begin tick(); cyc++; end
        for (int k = 0; k < 10; k++) begin
            check("bp_valid", 32'(out_valid), 1);
            check("bp_port", 32'(out_port), 8'h5A);
            check("bp_pc", 32'(pc), 2);
            tick();
        end
        check("bp_no_xfer", got_q.size(), 0);
        out_ready = 1'b1;
        check("bp_valid_last", 32'(out_valid), 1);
        tick();
        check("bp_drop", 32'(out_valid), 0);
        check("bp_xfers", got_q.size(), 1);
        check("bp_held", valid_cnt, 11);
        check("bp_xfer_val", 32'(got_q.size() > 0 ? got_q[0] : 8'h00), 8'h5A);

        // Fill data RAM with known values, then reset (RAM keeps contents)
        for (int a = 0; a < 16; a++) begin
            mram[a] = int'($urandom_range(0, 255));
            prog[2*a]   = ins(1, mram[a]);
            prog[2*a+1] = ins(8, a);
        end
        reset1();
        for (int k = 0; k < 64; k++) tick();

        // Random programs against the instruction-level model
        rand_ready = 1;
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 32; i++)
                prog[i] = ins(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
            reset1();
            mpc = 0; macc = 0; mz = 0; mc = 0; mhalt = 0;
            exp_q.delete();
            for (int s = 0; s < 40; s++) begin
                check("rnd_pc", 32'(pc), mpc);
                check("rnd_acc", 32'(acc), macc);
                if (mhalt != 0) begin
                    check("rnd_halted", 32'(halted), 1);
                    break;
                end
                op = int'(prog[mpc][11:8]);
                model_step(prog[mpc]);
                cyc = 0;
                do begin tick(); cyc++; end while (!fetch && !halted && cyc < 200);
                if (op == 12) check("rnd_out_cycles", 32'(cyc >= 3), 1);
                else check("rnd_cycles", cyc, 2);
            end
            check("rnd_out_count", got_q.size(), exp_q.size());
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
                check("rnd_out_val", 32'(got_q[i]), exp_q[i]);
        end
        rand_ready = 0;
        out_ready = 1'b1;

        // PC_W=3: eight NOPs wrap the pc
        reset2();
        for (int i = 0; i < 9; i++) begin
            check("wrap_fetch", 32'(fetch2), 1);
            check("wrap_pc", 32'(pc2), i % 8);
            tick();
            tick();
        end

        // Reset in the middle of an output handshake
        prog2[0] = ins2(1, 'h1234); prog2[1] = ins2(12, 0); prog2[2] = ins2(15, 0);
        ready2 = 1'b0;
        reset2();
        cyc = 0;
        while (!out_valid2 && cyc < 20) begin tick(); cyc++; end
        check("ow_valid", 32'(out_valid2), 1);
        tick(); tick();
        rst2 = 1'b1;
        tick();
        check("ow_rst_valid", 32'(out_valid2), 0);
        check("ow_rst_pc", 32'(pc2), 0);
        check("ow_rst_fetch", 32'(fetch2), 1);
        check("ow_rst_port", 32'(out_port2), 0);
        check("ow_rst_acc", 32'(acc2), 0);
        rst2 = 1'b0;
        ready2 = 1'b1;

        // DATA_W=16 borrow: 0 - 1 = FFFF, C=1, Z=0
        prog2[0] = ins2(1, 0); prog2[1] = ins2(3, 1); prog2[2] = ins2(10, 7);
        prog2[3] = ins2(11, 5); prog2[4] = ins2(15, 0); prog2[5] = ins2(15, 0);
        prog2[6] = ins2(0, 0); prog2[7] = ins2(15, 0);
        reset2();
        cyc = 0;
        while (!halted2 && cyc < 40) begin tick(); cyc++; end
        check("w16_halted", 32'(halted2), 1);
        check("w16_acc", 32'(acc2), 16'hFFFF);
        check("w16_pc", 32'(pc2), 6);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
